// File: rtl/sel_arbiter.sv
// sel_arbiter: round-robin arbiter/sequencer driving the shared sel/en/d datapath.
// Optional build macro: SEL_ARBITER_PRIO0_EN (requester 0 becomes high priority).
module sel_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_data,
    input  logic [NREQ-1:0] req_last,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      sel,
    output logic            en,
    output logic            d,
    output logic            busy
);

    localparam int unsigned IW = 2;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IW-1:0]   sel_nxt;
    logic            en_nxt;
    logic            d_nxt;
    logic            busy_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   beat_cnt, beat_nxt;
    logic [CW-1:0]   idle_cnt, idle_nxt;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            accept;
    logic            release_g;

    // Owner may push a beat only while the grant is live
    assign req_ready = (state == OWN) ? grant : '0;
    assign accept    = (state == OWN) && req_valid[sel];

    // Choose the next owner: first valid at/after the pointer, optionally requester 0 first
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
`ifdef SEL_ARBITER_PRIO0_EN
        if (req_valid[0]) begin
            pick_found = 1'b1;
        end
`endif
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = IW'((int'(ptr) + i) % int'(NREQ));
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        en_nxt    = 1'b0;
        d_nxt     = d;
        ptr_nxt   = ptr;
        beat_nxt  = beat_cnt;
        idle_nxt  = idle_cnt;
        release_g = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = OWN;
                    grant_nxt = NREQ'(1) << pick_idx;
                    sel_nxt   = pick_idx;
                end
            end
            OWN: begin
                if (accept) begin
                    en_nxt   = 1'b1;
                    d_nxt    = req_data[sel];
                    beat_nxt = beat_cnt + CW'(1);
                    idle_nxt = '0;
                    if (req_last[sel] || (beat_cnt + CW'(1) == CW'(MAX_BEATS))) begin
                        release_g = 1'b1;
                    end
                end else begin
                    idle_nxt = idle_cnt + CW'(1);
                    if (idle_cnt + CW'(1) == CW'(MAX_BEATS)) begin
                        release_g = 1'b1;
                    end
                end
                if (release_g) begin
`ifdef SEL_ARBITER_PRIO0_EN
                    if (sel != '0) begin
                        ptr_nxt = IW'((int'(sel) + 1) % int'(NREQ));
                    end
`else
                    ptr_nxt = IW'((int'(sel) + 1) % int'(NREQ));
`endif
                    beat_nxt  = '0;
                    idle_nxt  = '0;
                    grant_nxt = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            en       <= 1'b0;
            d        <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            en       <= en_nxt;
            d        <= d_nxt;
            busy     <= busy_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_nxt;
            idle_cnt <= idle_nxt;
        end
    end

endmodule

// File: tb/tb_sel_arbiter.sv
// Directed testbench for sel_arbiter (default NREQ=4, MAX_BEATS=4).
module tb_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_data;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       en;
    logic       d;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    sel_arbiter #(.NREQ(4), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .sel       (sel),
        .en        (en),
        .d         (d),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] dat;
        logic [3:0] gexp;
        int         en_count;
        logic       en_exp;
        logic       g_on;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset held two cycles
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_sel", 32'(sel), 32'(0));
        check("rst_en", 32'(en), 32'(0));
        check("rst_d", 32'(d), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        rst_n = 1'b1;

        // Single 3-beat burst from requester 1: data 1,0,1
        req_valid = 4'b0010;
        req_data  = 4'b0010;
        tick();
        check("b_grant", 32'(grant), 32'(4'b0010));
        check("b_sel", 32'(sel), 32'(1));
        check("b_ready", 32'(req_ready), 32'(4'b0010));
        check("b_busy", 32'(busy), 32'(1));
        check("b_en0", 32'(en), 32'(0));
        tick();
        check("b_en1", 32'(en), 32'(1));
        check("b_d1", 32'(d), 32'(1));
        req_data = 4'b0000;
        tick();
        check("b_en2", 32'(en), 32'(1));
        check("b_d2", 32'(d), 32'(0));
        req_data = 4'b0010;
        req_last = 4'b0010;
        tick();
        check("b_en3", 32'(en), 32'(1));
        check("b_d3", 32'(d), 32'(1));
        check("b_gap_grant", 32'(grant), 32'(0));
        check("b_gap_ready", 32'(req_ready), 32'(0));
        check("b_gap_busy", 32'(busy), 32'(1));
        req_valid = '0;
        req_last  = '0;
        tick();
        check("b_idle_busy", 32'(busy), 32'(0));
        check("b_idle_en", 32'(en), 32'(0));
        check("b_sel_hold", 32'(sel), 32'(1));

        // Round-robin: everyone valid with last on every beat, pointer reset to 0
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        dat       = 4'b1010;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = dat;
        for (int k = 0; k < 5; k++) begin
            gexp = 4'b0001 << (k % 4);
            tick();
            check("rr_grant", 32'(grant), 32'(gexp));
            check("rr_sel", 32'(sel), 32'(k % 4));
            check("rr_ready", 32'(req_ready), 32'(gexp));
            check("rr_en_off", 32'(en), 32'(0));
            tick();
            check("rr_en", 32'(en), 32'(1));
            check("rr_d", 32'(d), 32'(dat[k % 4]));
            check("rr_gap_grant", 32'(grant), 32'(0));
            tick();
            check("rr_idle_en", 32'(en), 32'(0));
            check("rr_idle_busy", 32'(busy), 32'(0));
        end
        req_valid = '0;
        req_last  = '0;

        // Burst limit: requester 2 streams 10 beats without last
        req_valid = 4'b0100;
        req_data  = 4'b0100;
        en_count  = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            en_exp = ((c >= 2) && (c <= 5)) || ((c >= 8) && (c <= 11)) || (c == 14) || (c == 15);
            g_on   = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 10)) || ((c >= 13) && (c <= 18));
            check("lim_en", 32'(en), 32'(en_exp));
            check("lim_grant", 32'(grant), g_on ? 32'(4'b0100) : 32'(0));
            if (en) en_count++;
            if (c == 15) req_valid = '0;
        end
        check("lim_en_count", 32'(en_count), 32'(10));
        check("lim_busy_end", 32'(busy), 32'(0));

        // Idle timeout: requester 3 sends one beat then goes quiet
        req_valid = 4'b1000;
        req_data  = 4'b1000;
        tick();
        check("to_grant", 32'(grant), 32'(4'b1000));
        tick();
        check("to_en", 32'(en), 32'(1));
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("to_hold_grant", 32'(grant), 32'(4'b1000));
            check("to_hold_en", 32'(en), 32'(0));
        end
        tick();
        check("to_rel_grant", 32'(grant), 32'(0));
        check("to_rel_busy", 32'(busy), 32'(1));
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 4'b0000;
        tick();
        check("to_idle_busy", 32'(busy), 32'(0));
        tick();
        check("to_next_grant", 32'(grant), 32'(4'b0001));
        check("to_next_sel", 32'(sel), 32'(0));
        tick();
        req_valid = '0;
        req_last  = '0;
        tick();

        // Reset during the second beat of a requester 1 burst
        req_valid = 4'b0010;
        req_data  = 4'b0010;
        tick();
        check("mr_grant", 32'(grant), 32'(4'b0010));
        tick();
        check("mr_en1", 32'(en), 32'(1));
        rst_n = 1'b0;
        tick();
        check("mr_en", 32'(en), 32'(0));
        check("mr_grant0", 32'(grant), 32'(0));
        check("mr_sel0", 32'(sel), 32'(0));
        check("mr_busy0", 32'(busy), 32'(0));
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        tick();
        check("mr_regrant", 32'(grant), 32'(4'b0001));
        req_valid = '0;
        tick();
        tick();
        tick();
        tick();
        tick();

`ifdef SEL_ARBITER_PRIO0_EN
        // Priority: pointer at 2, requesters 0 and 2 valid
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        tick();
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        tick();
        check("p0_grant", 32'(grant), 32'(4'b0001));
        tick();
        req_valid = 4'b0100;
        tick();
        tick();
        check("p0_next_grant", 32'(grant), 32'(4'b0100));
        req_valid = '0;
        req_last  = '0;
        tick();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sel_arbiter.md
# sel_arbiter

Round-robin arbiter and sequencer for the shared single-bit mux/flop datapath (2-bit `sel`, `en`, `d`). Up to four requesters each present a valid/ready stream. The arbiter grants one owner at a time for a bounded burst and drives the datapath's select, enable and data from a registered stage. It sits directly in front of the mux/enable-flop pair and is the only driver of its control inputs.

## Interface
- `NREQ`, 4: number of requesters, legal 2..4 (must fit the 2-bit `sel`).
- `MAX_BEATS`, 4: maximum accepted beats per grant and idle-timeout length in cycles, legal 1..15.

- `clk` input 1: single clock, all state on posedge.
- `rst_n` input 1: reset, synchronous, active-low. Sampled on posedge `clk`.
- `req_valid` input NREQ: per-requester beat valid.
- `req_data` input NREQ: per-requester data bit.
- `req_last` input NREQ: per-requester end-of-burst marker, qualified by valid.
- `req_ready` output NREQ: per-requester beat accept. Combinational from registered state only.
- `grant` output NREQ: one-hot current owner. Registered.
- `sel` output 2: datapath select, equal to the owner index. Registered.
- `en` output 1: datapath enable, one-cycle pulse per accepted beat. Registered.
- `d` output 1: datapath data for the beat. Registered.
- `busy` output 1: high when state is not IDLE.

## Operation
- Three states: IDLE, OWN, GAP.
- Reset values: state=IDLE, `grant`=0, `sel`=0, `en`=0, `d`=0, `busy`=0, round-robin pointer=0, beat counter=0, idle counter=0.
- **IDLE:**
  - If any `req_valid` is high, pick the first valid index at or after the pointer, wrapping modulo NREQ.
  - Load `grant` and `sel` with that index and go to OWN.
  - Otherwise stay in IDLE.
- **OWN:**
  - `req_ready[owner]`=1; every other `req_ready` is 0.
  - A beat is accepted when `req_valid[owner]` and `req_ready[owner]` are both high.
  - On an accepted beat:
    - Next cycle, `en`=1 and `d`=`req_data[owner]`.
    - The beat counter increments and the idle counter clears.
  - Release the grant when either of these holds:
    - an accepted beat has `req_last`=1;
    - an accepted beat brings the beat counter to MAX_BEATS.
  - With no accepted beat in a cycle, the idle counter increments. Release when it reaches MAX_BEATS.
  - On release:
    - The pointer becomes owner+1, wrapping modulo NREQ.
    - Clear both counters, clear `grant`, and go to GAP.
    - `sel` holds its last value.
- **GAP:** exactly one turnaround cycle. All `req_ready`=0. Go to IDLE unconditionally.
- `en` is 0 in every cycle not following an accepted beat. This includes the `en` pulse for the last beat, which lands in the GAP cycle.
- Simultaneous `req_last` and counter limit on the same beat: a single release.
- MAX_BEATS=1: every grant ends after one beat.
- Bits of `req_valid` at indices ≥ NREQ do not exist. Requests from non-owners are ignored until IDLE.
- `rst_n` low in any state, mid-burst included:
  - Next edge restores all reset values.
  - A beat accepted in that same cycle produces no `en` pulse.

## Timing
- Request to grant: a request seen in IDLE gives `grant`/`sel` valid the next cycle and `req_ready` high that same cycle.
- Beat accept to `en`/`d` at the datapath: 1 cycle.
- Grant-to-grant turnaround: release edge, then one GAP cycle, then one IDLE arbitration cycle, so the new owner is ready on the 3rd cycle after the last beat.
- Throughput: 1 beat/cycle within a grant.
- `sel` is stable whenever `en`=1.

## Configuration
- `SEL_ARBITER_PRIO0_EN`
  - Defined: requester 0 is high priority. In IDLE, `req_valid[0]` wins regardless of the pointer. A requester-0 grant does not move the pointer.
  - Undefined: pure round-robin as described above.

## Test plan
- Reset then a single burst: `rst_n` low 2 cycles. Req1 sends data 1,0,1 with `req_last` on the 3rd beat. Expect `grant`=0010 and `sel`=1, `en` pulses on 3 consecutive cycles with `d`=1,0,1, then `busy` falls 2 cycles after the last beat.
- Round-robin fairness: all 4 requesters valid continuously with `req_last` on each beat. Expect grant order 0,1,2,3,0 and exactly one `en` pulse per grant.
- Burst limit: req2 streams 10 beats with no `req_last`, MAX_BEATS=4. Expect release after beats 4 and 8 with re-grant to req2 each time (no other requesters), and 10 total `en` pulses.
- Idle timeout: req3 is granted, sends 1 beat, then drops valid. Expect release after exactly 4 idle cycles, and the next grant goes to req0.
- Reset mid-burst: `rst_n` low during the 2nd beat of a req1 burst. Expect no `en` the next cycle, `grant`=0, `sel`=0, and the pointer reset so req0 wins the next arbitration.
- With `SEL_ARBITER_PRIO0_EN` defined: pointer at 2, req0 and req2 both valid. Expect req0 granted, then req2.
